instruction_block_fetcher: RTL



---
 rtl/instruction_block_fetcher.sv | 124 ++++++++++++
 1 files changed

// File: rtl/instruction_block_fetcher.sv
// instruction_block_fetcher: fills one instruction-cache block from a narrow Wishbone memory.
//   CLK_I, RST_I            clock; synchronous active-high reset
//   inst_CYC_I/STB_I/ADR_I  block request from the cache (any byte address inside the block)
//   inst_DAT_O/ACK_O        assembled block (word 0 in the LSBs) and its one-cycle acknowledge
//   mem_CYC_O/STB_O/ADR_O   sequential word reads toward memory (byte address, word aligned)
//   mem_DAT_I/ACK_I         memory read data and acknowledge
//   LAST_BLOCK_BUFFER_EN    when defined, a repeat request for the last completely fetched block
//                           is acknowledged straight away without touching memory
module instruction_block_fetcher #(
    parameter int L2_BLOCK_SIZE    = 6,
    parameter int L2_ADDR_SIZE     = 32,
    parameter int L2_MEM_DATA_SIZE = 2
) (
    input  logic                               CLK_I,
    input  logic                               RST_I,
    input  logic                               inst_CYC_I,
    input  logic                               inst_STB_I,
    input  logic [L2_ADDR_SIZE-1:0]            inst_ADR_I,
    output logic [2**(L2_BLOCK_SIZE+3)-1:0]    inst_DAT_O,
    output logic                               inst_ACK_O,
    output logic                               mem_CYC_O,
    output logic                               mem_STB_O,
    output logic [L2_ADDR_SIZE-1:0]            mem_ADR_O,
    input  logic [2**(L2_MEM_DATA_SIZE+3)-1:0] mem_DAT_I,
    input  logic                               mem_ACK_I
);
    localparam int N  = 2**(L2_BLOCK_SIZE-L2_MEM_DATA_SIZE);
    localparam int W  = 2**(L2_MEM_DATA_SIZE+3);
    localparam int BW = 2**(L2_BLOCK_SIZE+3);
    localparam int IW = (L2_BLOCK_SIZE > L2_MEM_DATA_SIZE) ? L2_BLOCK_SIZE-L2_MEM_DATA_SIZE : 1;
    localparam logic [L2_ADDR_SIZE-1:0] BLK_MASK  = {L2_ADDR_SIZE{1'b1}} << L2_BLOCK_SIZE;
    localparam logic [L2_ADDR_SIZE-1:0] WORD_STEP = L2_ADDR_SIZE'(1) << L2_MEM_DATA_SIZE;
    localparam logic [IW-1:0]           LAST      = IW'(N-1);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [L2_ADDR_SIZE-1:0] adr_q, adr_d;
    logic [BW-1:0]           dat_q, dat_d;
    logic                    hit;

`ifdef LAST_BLOCK_BUFFER_EN
    logic                    valid_q, valid_d;
    logic [L2_ADDR_SIZE-1:0] tag_q, tag_d;
    assign hit = valid_q && ((inst_ADR_I & BLK_MASK) == tag_q);
`else
    assign hit = 1'b0;
`endif

    assign inst_DAT_O = dat_q;
    assign inst_ACK_O = (state_q == DONE);
    assign mem_CYC_O  = (state_q == FETCH);
    assign mem_STB_O  = (state_q == FETCH);
    assign mem_ADR_O  = adr_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
`ifdef LAST_BLOCK_BUFFER_EN
        valid_d = valid_q;
        tag_d   = tag_q;
`endif
        case (state_q)
            IDLE: begin
                if (inst_CYC_I && inst_STB_I) begin
                    state_d = hit ? DONE : FETCH;
                    idx_d   = '0;
                    adr_d   = hit ? '0 : (inst_ADR_I & BLK_MASK);
                end
            end
            FETCH: begin
                // A dropped cycle wins over a same-cycle memory ack, so the ack is discarded.
                if (!inst_CYC_I) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    adr_d   = '0;
`ifdef LAST_BLOCK_BUFFER_EN
                    valid_d = 1'b0;
`endif
                end else if (mem_ACK_I) begin
                    dat_d[idx_q*W +: W] = mem_DAT_I;
                    if (idx_q == LAST) begin
                        state_d = DONE;
                        idx_d   = '0;
                        adr_d   = '0;
`ifdef LAST_BLOCK_BUFFER_EN
                        valid_d = 1'b1;
                        tag_d   = adr_q & BLK_MASK;
`endif
                    end else begin
                        idx_d = idx_q + IW'(1);
                        adr_d = adr_q + WORD_STEP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            idx_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
`ifdef LAST_BLOCK_BUFFER_EN
            valid_q <= 1'b0;
            tag_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
`ifdef LAST_BLOCK_BUFFER_EN
            valid_q <= valid_d;
            tag_q   <= tag_d;
`endif
        end
    end
endmodule
